// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode seven-segment scan multiplexer, stepped by a sampled divided clock.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_mux #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_clk,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W = 7;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_INV   = {NUM_DIGITS{SEG_ACTIVE_LOW == 0}};
    localparam logic [SEG_W-1:0]      SEG_INV  = {SEG_W{SEG_ACTIVE_LOW == 0}};
    localparam logic                  DP_INV   = (SEG_ACTIVE_LOW == 0);

    logic                  scan_clk_q;
    logic [IDX_W-1:0]      idx;
    logic [BCD_W-1:0]      bcd_shadow;
    logic [NUM_DIGITS-1:0] dp_shadow;

    logic                  step;
    logic                  adv;
    logic                  wrap;
    logic                  blank;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] an_al;
    logic [SEG_W-1:0]      seg_al;
    logic                  dp_al;

    // Active-low {g,f,e,d,c,b,a} pattern; non-BCD codes show a dash.
    function automatic logic [SEG_W-1:0] decode(input logic [3:0] v);
        logic [SEG_W-1:0] r;
        case (v)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = 7'b0111111;
        endcase
        return r;
    endfunction

    assign step   = scan_clk & ~scan_clk_q;
    assign adv    = step & enable;
    assign wrap   = adv & (idx == LAST_IDX);
    assign nibble = bcd_shadow[4*idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant nibble are zero.
    assign blank = (idx != IDX_W'(0)) && ((bcd_shadow >> (4*idx)) == BCD_W'(0));
`else
    assign blank = 1'b0;
`endif

    // Next display drive, computed in active-low form and re-polarised at the register.
    always_comb begin
        an_al  = '1;
        seg_al = '1;
        dp_al  = 1'b1;
        if (enable) begin
            an_al  = ~(NUM_DIGITS'(1) << idx);
            seg_al = blank ? '1 : decode(nibble);
            dp_al  = ~dp_shadow[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_clk_q <= 1'b0;
            idx        <= '0;
            bcd_shadow <= '0;
            dp_shadow  <= '0;
            frame_done <= 1'b0;
            an         <= ~AN_INV;
            seg        <= ~SEG_INV;
            dp         <= ~DP_INV;
        end else begin
            scan_clk_q <= scan_clk;
            if (adv) begin
                idx <= idx + IDX_W'(1);
            end
            // New value is taken only at the frame wrap so a frame never mixes two values.
            if (wrap) begin
                bcd_shadow <= bcd_in;
                dp_shadow  <= dp_in;
            end
            frame_done <= wrap;
            an         <= an_al ^ AN_INV;
            seg        <= seg_al ^ SEG_INV;
            dp         <= dp_al ^ DP_INV;
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised scoreboard bench for seg7_scan_mux against a digit-level display model.
module tb_seg7_scan_mux;
    logic        clk = 1'b0;
    logic        reset;
    logic        scan_clk;
    logic        enable;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_mux dut (
        .clk        (clk),
        .reset      (reset),
        .scan_clk   (scan_clk),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Model state: which digit is lit, what the display currently holds, last scan level.
    int m_pos;
    int m_digit[4];
    bit m_dpv[4];
    bit m_prev;

    // Seven-segment glyphs described by the letters that light up.
    function automatic logic [6:0] glyph(int v);
        string s;
        logic [6:0] r;
        case (v)
            0: s = "abcdef";
            1: s = "bc";
            2: s = "abdeg";
            3: s = "abcdg";
            4: s = "bcfg";
            5: s = "acdfg";
            6: s = "acdefg";
            7: s = "abc";
            8: s = "abcdefg";
            9: s = "abcdfg";
            default: s = "g";
        endcase
        r = 7'b1111111;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    function automatic bit leading_zero(int pos);
        bit z;
        z = (pos != 0);
        for (int k = pos; k < 4; k++) if (m_digit[k] != 0) z = 0;
`ifdef LEADING_ZERO_BLANK_EN
        return z;
`else
        return 1'b0 & z;
`endif
    endfunction

    // Predict what the display shows after the coming clock edge, then advance the model.
    task automatic model_step(bit rst, bit sc, bit en, logic [15:0] b, logic [3:0] d);
        exp_t e;
        bit   rise;
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.fd = 1'b0;
        if (rst) begin
            m_pos = 0; m_prev = 0;
            for (int k = 0; k < 4; k++) begin m_digit[k] = 0; m_dpv[k] = 0; end
        end else begin
            rise = sc && !m_prev;
            if (en) begin
                e.an[m_pos] = 1'b0;
                e.seg = leading_zero(m_pos) ? 7'b1111111 : glyph(m_digit[m_pos]);
                e.dp = !m_dpv[m_pos];
            end
            e.fd = rise && en && (m_pos == 3);
            if (rise && en) begin
                if (m_pos == 3) begin
                    for (int k = 0; k < 4; k++) begin
                        m_digit[k] = int'(b[4*k +: 4]);
                        m_dpv[k]   = d[k];
                    end
                end
                m_pos = (m_pos + 1) % 4;
            end
            m_prev = sc;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(bit rst, bit sc, bit en, logic [15:0] b, logic [3:0] d);
        @(negedge clk);
        reset = rst; scan_clk = sc; enable = en; bcd_in = b; dp_in = d;
        model_step(rst, sc, en, b, d);
    endtask

    logic [15:0] cur_bcd = 16'h0000;
    logic [3:0]  cur_dp  = 4'b0000;
    bit          cur_en  = 1'b1;

    task automatic scan_periods(int n, int half);
        for (int p = 0; p < n; p++) begin
            for (int h = 0; h < half; h++) drive(0, 1, cur_en, cur_bcd, cur_dp);
            for (int h = 0; h < half; h++) drive(0, 0, cur_en, cur_bcd, cur_dp);
        end
    endtask

    // Step the scan until the model points at the wanted digit (bounded).
    task automatic scan_to(int pos);
        for (int g = 0; g < 8 && m_pos != pos; g++) begin
            drive(0, 1, cur_en, cur_bcd, cur_dp);
            drive(0, 0, cur_en, cur_bcd, cur_dp);
        end
    endtask

    task automatic cmp(string nm, logic [6:0] act, logic [6:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, want);
        end
    endtask

    // Monitor: one registered display word per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("an",         7'(an),         7'(e.an));
                cmp("seg",        seg,            e.seg);
                cmp("dp",         7'(dp),         7'(e.dp));
                cmp("frame_done", 7'(frame_done), 7'(e.fd));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r;
        bit          sc;
        bit          rst;
        // Reset held three cycles with enable high, then first steps show 0.
        repeat (3) drive(1, 0, 1, 16'h0000, 4'b0000);
        scan_periods(2, 2);

        // Steady 1234 with dp on digit 2.
        cur_bcd = 16'h1234; cur_dp = 4'b0100;
        scan_periods(8, 4);

        // Mid-frame change must not tear the current frame.
        scan_to(1);
        cur_bcd = 16'h5678; cur_dp = 4'b0001;
        scan_periods(6, 3);

        // Invalid BCD digit and leading zeros.
        cur_bcd = 16'h00A9; cur_dp = 4'b0000;
        scan_periods(6, 2);

        // Long high scan level advances only once.
        repeat (20) drive(0, 1, 1, cur_bcd, cur_dp);
        drive(0, 0, 1, cur_bcd, cur_dp);

        // Disable mid-frame, then resume from the held digit.
        scan_to(2);
        cur_en = 0;
        scan_periods(3, 2);
        cur_en = 1;
        scan_periods(3, 2);

        // Step coinciding with enable falling at the last digit.
        cur_bcd = 16'h4321;
        scan_to(3);
        drive(0, 0, 1, cur_bcd, cur_dp);
        drive(0, 1, 0, cur_bcd, cur_dp);
        drive(0, 1, 0, cur_bcd, cur_dp);
        drive(0, 0, 0, cur_bcd, cur_dp);
        repeat (3) drive(0, 0, 1, cur_bcd, cur_dp);

        // Reset mid-frame.
        scan_to(2);
        drive(1, 1, 1, cur_bcd, cur_dp);
        scan_periods(5, 2);

        // Random traffic.
        sc = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2) == 0) sc = !sc;
            cur_en = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) begin
                r = 16'($urandom);
                case ($urandom_range(3))
                    0: r = r & 16'h00FF;
                    1: r = r & 16'h000F;
                    2: r = 16'h0000;
                    default: ;
                endcase
                cur_bcd = r;
                cur_dp  = 4'($urandom);
            end
            rst = ($urandom_range(199) == 0);
            drive(rst, sc, cur_en, cur_bcd, cur_dp);
        end

        for (int g = 0; g < 4 && exp_q.size() > 0; g++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
